// File: rtl/jtag_dr_scan_controller.sv
// JTAG IR/DR scan controller behind the TAP state machine.
// Sequences capture/shift/update of IR and IDCODE/BYPASS/USER chains.
module jtag_dr_scan_controller #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
    parameter int          USER_WIDTH   = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic [4:0]            tap_state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir_value,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic [USER_WIDTH-1:0] user_update_data,
    output logic                  user_update_valid,
    output logic                  abort_pulse
);

    localparam logic [4:0] TEST_LOGIC_RESET = 5'h00;
    localparam logic [4:0] CAPTURE_DR       = 5'h04;
    localparam logic [4:0] CAPTURE_IR       = 5'h05;
    localparam logic [4:0] SHIFT_DR         = 5'h06;
    localparam logic [4:0] SHIFT_IR         = 5'h07;
    localparam logic [4:0] UPDATE_DR        = 5'h14;
    localparam logic [4:0] UPDATE_IR        = 5'h15;

    localparam logic [IR_WIDTH-1:0] IR_ABORT   = IR_WIDTH'(4'b1000);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(4'b1010);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(4'b1110);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101);

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           id_sr;
    logic                  bypass_sr;
    logic [USER_WIDTH-1:0] user_sr;

    logic sel_idcode;
    logic sel_user;
    logic sel_abort;
    logic sel_bypass;

    // Undefined codes (and ABORT) fall back to the 1-bit BYPASS chain.
    assign sel_idcode = (ir_value == IR_IDCODE);
    assign sel_user   = (ir_value == IR_USER);
    assign sel_abort  = (ir_value == IR_ABORT);
    assign sel_bypass = !sel_idcode && !sel_user;

    // Instruction register: capture, shift, and commit to ir_value.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_value <= IR_IDCODE;
            ir_sr    <= '0;
        end else begin
            case (tap_state)
                TEST_LOGIC_RESET: ir_value <= IR_IDCODE;
                CAPTURE_IR:       ir_sr    <= IR_CAPTURE;
                SHIFT_IR:         ir_sr    <= {tdi, ir_sr[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_value <= ir_sr;
                default:          ;
            endcase
        end
    end

    // Data registers: only the chain selected by ir_value moves.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            id_sr     <= IDCODE_VALUE;
            bypass_sr <= 1'b0;
            user_sr   <= '0;
        end else begin
            case (tap_state)
                CAPTURE_DR: begin
                    if (sel_idcode) id_sr     <= IDCODE_VALUE;
                    if (sel_bypass) bypass_sr <= 1'b0;
                    if (sel_user)   user_sr   <= user_capture_data;
                end
                SHIFT_DR: begin
                    if (sel_idcode) id_sr     <= {tdi, id_sr[31:1]};
                    if (sel_bypass) bypass_sr <= tdi;
                    if (sel_user)   user_sr   <= {tdi, user_sr[USER_WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    // Update strobes; UpdateDr lasts one tck so each pulse is one cycle.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_update_data  <= '0;
            user_update_valid <= 1'b0;
            abort_pulse       <= 1'b0;
        end else begin
            user_update_valid <= (tap_state == UPDATE_DR) && sel_user;
            abort_pulse       <= (tap_state == UPDATE_DR) && sel_abort;
            if ((tap_state == UPDATE_DR) && sel_user)
                user_update_data <= user_sr;
        end
    end

    // Serial output: LSB of the active register, forced low in reset.
    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (!trst) begin
            case (tap_state)
                SHIFT_IR: begin
                    tdo    = ir_sr[0];
                    tdo_en = 1'b1;
                end
                SHIFT_DR: begin
                    tdo_en = 1'b1;
                    if (sel_user)        tdo = user_sr[0];
                    else if (sel_idcode) tdo = id_sr[0];
                    else                 tdo = bypass_sr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dr_scan_controller.sv
// Self-checking bench for jtag_dr_scan_controller.
// Table vectors plus hand sequences; tdo expectations go through a queue.
module tb_jtag_dr_scan_controller;

    localparam logic [4:0] TLR   = 5'h00;
    localparam logic [4:0] RTI   = 5'h01;
    localparam logic [4:0] SELDR = 5'h02;
    localparam logic [4:0] SELIR = 5'h03;
    localparam logic [4:0] CAPDR = 5'h04;
    localparam logic [4:0] CAPIR = 5'h05;
    localparam logic [4:0] SHDR  = 5'h06;
    localparam logic [4:0] SHIR  = 5'h07;
    localparam logic [4:0] EX1DR = 5'h08;
    localparam logic [4:0] EX1IR = 5'h09;
    localparam logic [4:0] PSDR  = 5'h10;
    localparam logic [4:0] EX2DR = 5'h12;
    localparam logic [4:0] UPDR  = 5'h14;
    localparam logic [4:0] UPIR  = 5'h15;

    localparam logic [31:0] IDCODE = 32'h000FAF01;

    typedef struct {
        logic [4:0] st;
        logic       d;
        logic       et;
        logic       ee;
    } vec_t;

    logic       tck;
    logic       trst;
    logic [4:0] tap_state;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_value;
    logic [7:0] user_capture_data;
    logic [7:0] user_update_data;
    logic       user_update_valid;
    logic       abort_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    jtag_dr_scan_controller dut (
        .tck               (tck),
        .trst              (trst),
        .tap_state         (tap_state),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .ir_value          (ir_value),
        .user_capture_data (user_capture_data),
        .user_update_data  (user_update_data),
        .user_update_valid (user_update_valid),
        .abort_pulse       (abort_pulse)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one TAP cycle at negedge; expected tdo/tdo_en go to the queue.
    task automatic drive(input logic [4:0] st, input logic d,
                         input logic et, input logic ee);
        logic [1:0] e;
        @(negedge tck);
        tap_state = st;
        tdi       = d;
        exp_q.push_back({et, ee});
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("tdo", {31'd0, tdo}, {31'd0, e[1]});
            chk("tdo_en", {31'd0, tdo_en}, {31'd0, e[0]});
        end
    endtask

    // Captured IR is 0101, so tdo always reads 1,0,1,0 regardless of tdi.
    task automatic load_ir(input logic [3:0] v);
        logic [3:0] cap;
        cap = 4'b0101;
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(SELIR, 1'b0, 1'b0, 1'b0);
        drive(CAPIR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(SHIR, v[i], cap[i], 1'b1);
        drive(EX1IR, 1'b0, 1'b0, 1'b0);
        drive(UPIR, 1'b0, 1'b0, 1'b0);
        drive(RTI, 1'b0, 1'b0, 1'b0);
        chk("ir_value_load", {28'd0, ir_value}, {28'd0, v});
    endtask

    task automatic idcode_scan();
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++)
            drive(SHDR, 1'b0, IDCODE[i], 1'b1);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        drive(UPDR, 1'b0, 1'b0, 1'b0);
        drive(RTI, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t tbl[18];
        logic [7:0] shin;
        logic [7:0] cap;
        logic [7:0] u_pat;

        tbl = '{
            '{SELDR, 1'b0, 1'b0, 1'b0},
            '{SELIR, 1'b0, 1'b0, 1'b0},
            '{CAPIR, 1'b0, 1'b0, 1'b0},
            '{SHIR,  1'b1, 1'b1, 1'b1},
            '{SHIR,  1'b1, 1'b0, 1'b1},
            '{SHIR,  1'b1, 1'b1, 1'b1},
            '{SHIR,  1'b1, 1'b0, 1'b1},
            '{EX1IR, 1'b0, 1'b0, 1'b0},
            '{UPIR,  1'b0, 1'b0, 1'b0},
            '{SELDR, 1'b0, 1'b0, 1'b0},
            '{CAPDR, 1'b0, 1'b0, 1'b0},
            '{SHDR,  1'b1, 1'b0, 1'b1},
            '{SHDR,  1'b0, 1'b1, 1'b1},
            '{SHDR,  1'b1, 1'b0, 1'b1},
            '{SHDR,  1'b1, 1'b1, 1'b1},
            '{EX1DR, 1'b0, 1'b0, 1'b0},
            '{UPDR,  1'b0, 1'b0, 1'b0},
            '{RTI,   1'b0, 1'b0, 1'b0}
        };

        trst              = 1'b1;
        tap_state         = TLR;
        tdi               = 1'b0;
        user_capture_data = 8'h00;
        #2;
        chk("rst_ir_value", {28'd0, ir_value}, 32'hE);
        chk("rst_tdo", {31'd0, tdo}, 0);
        chk("rst_tdo_en", {31'd0, tdo_en}, 0);
        chk("rst_upd_data", {24'd0, user_update_data}, 0);
        chk("rst_upd_valid", {31'd0, user_update_valid}, 0);
        chk("rst_abort", {31'd0, abort_pulse}, 0);
        @(negedge tck);
        trst = 1'b0;

        // IDCODE readout from reset
        drive(TLR, 1'b0, 1'b0, 1'b0);
        drive(RTI, 1'b0, 1'b0, 1'b0);
        idcode_scan();

        // IR scan to BYPASS, then a 1-stage DR scan (table)
        for (int i = 0; i < 18; i++)
            drive(tbl[i].st, tbl[i].d, tbl[i].et, tbl[i].ee);
        chk("ir_value_bypass", {28'd0, ir_value}, 32'hF);

        // USER capture/shift/update with Pause/Exit2 resume mid-shift
        load_ir(4'hA);
        user_capture_data = 8'hA5;
        shin = 8'h3C;
        cap  = 8'hA5;
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(SHDR, shin[i], cap[i], 1'b1);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        drive(PSDR, 1'b1, 1'b0, 1'b0);
        drive(EX2DR, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i < 8; i++)
            drive(SHDR, shin[i], cap[i], 1'b1);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        chk("user_valid_pre", {31'd0, user_update_valid}, 0);
        drive(UPDR, 1'b0, 1'b0, 1'b0);
        @(posedge tck);
        #1;
        chk("user_valid_hi", {31'd0, user_update_valid}, 1);
        chk("user_upd_data", {24'd0, user_update_data}, 32'h3C);
        chk("abort_in_user", {31'd0, abort_pulse}, 0);
        drive(RTI, 1'b0, 1'b0, 1'b0);
        @(posedge tck);
        #1;
        chk("user_valid_lo", {31'd0, user_update_valid}, 0);
        chk("user_data_hold", {24'd0, user_update_data}, 32'h3C);

        // USER over-shift: 16 bits, second byte must echo the first
        user_capture_data = 8'h00;
        u_pat = 8'h96;
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(SHDR, u_pat[i], 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            drive(SHDR, 1'b0, u_pat[i], 1'b1);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        drive(RTI, 1'b0, 1'b0, 1'b0);

        // Undefined instruction behaves as BYPASS
        load_ir(4'h3);
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        drive(SHDR, 1'b1, 1'b0, 1'b1);
        drive(SHDR, 1'b1, 1'b1, 1'b1);
        drive(SHDR, 1'b0, 1'b1, 1'b1);
        drive(SHDR, 1'b0, 1'b0, 1'b1);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        drive(RTI, 1'b0, 1'b0, 1'b0);

        // ABORT: one-cycle abort_pulse, no user strobe
        load_ir(4'h8);
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        drive(EX1DR, 1'b0, 1'b0, 1'b0);
        chk("abort_pre", {31'd0, abort_pulse}, 0);
        drive(UPDR, 1'b0, 1'b0, 1'b0);
        @(posedge tck);
        #1;
        chk("abort_hi", {31'd0, abort_pulse}, 1);
        chk("abort_no_user", {31'd0, user_update_valid}, 0);
        drive(RTI, 1'b0, 1'b0, 1'b0);
        @(posedge tck);
        #1;
        chk("abort_lo", {31'd0, abort_pulse}, 0);

        // trst asserted mid USER shift
        load_ir(4'hA);
        user_capture_data = 8'hFF;
        drive(SELDR, 1'b0, 1'b0, 1'b0);
        drive(CAPDR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(SHDR, 1'b1, 1'b1, 1'b1);
        #1;
        trst = 1'b1;
        #1;
        chk("trst_tdo", {31'd0, tdo}, 0);
        chk("trst_tdo_en", {31'd0, tdo_en}, 0);
        chk("trst_ir_value", {28'd0, ir_value}, 32'hE);
        @(negedge tck);
        tap_state = UPDR;
        @(negedge tck);
        trst = 1'b0;
        tap_state = RTI;
        @(posedge tck);
        #1;
        chk("trst_no_valid", {31'd0, user_update_valid}, 0);
        chk("trst_upd_data", {24'd0, user_update_data}, 0);

        // TestLogicReset restores IDCODE
        load_ir(4'hF);
        for (int i = 0; i < 5; i++)
            drive(TLR, 1'b0, 1'b0, 1'b0);
        @(posedge tck);
        #1;
        chk("tlr_ir_value", {28'd0, ir_value}, 32'hE);
        drive(RTI, 1'b0, 1'b0, 1'b0);
        idcode_scan();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_dr_scan_controller.md
Name: jtag_dr_scan_controller

Overview:
Instruction-register and data-register scan controller that sits behind the TAP state machine in the jtag block. It watches the registered TAP state and sequences capture, shift and update of the IR and of the DR chain selected by the current instruction. Supported chains are IDCODE, BYPASS and an 8-bit USER register. It drives tdo and presents decoded update strobes to the core side.

Parameters:
IR_WIDTH, 4, instruction register width.
IDCODE_VALUE, 32'h000FAF01, value captured into the IDCODE DR.
USER_WIDTH, 8, USER data register width.

Ports:
tck  input  1  JTAG clock; all state changes on rising edge.
trst  input  1  asynchronous, active-high reset.
tap_state  input  5  registered TAP state: TestLogicReset=0x00, RunTestOrIdle=0x01, SelectDrScan=0x02, SelectIrScan=0x03, CaptureDr=0x04, CaptureIr=0x05, ShiftDr=0x06, ShiftIr=0x07, Exit1Dr=0x08, Exit1Ir=0x09, PauseDr=0x10, PauseIr=0x11, Exit2Dr=0x12, Exit2Ir=0x13, UpdateDr=0x14, UpdateIr=0x15.
tdi  input  1  serial data in.
tdo  output  1  serial data out.
tdo_en  output  1  high while tdo carries valid scan data.
ir_value  output  IR_WIDTH  active instruction.
user_capture_data  input  USER_WIDTH  core value loaded into the USER DR at CaptureDr.
user_update_data  output  USER_WIDTH  USER DR contents latched at UpdateDr.
user_update_valid  output  1  one-cycle strobe when user_update_data is updated.
abort_pulse  output  1  one-cycle strobe at UpdateDr while ABORT is active.

Behaviour:
- Instructions: ABORT=4'b1000, USER=4'b1010, IDCODE=4'b1110, BYPASS=4'b1111. Any other code selects the BYPASS chain.
- Reset values (trst high, applied asynchronously):
  - ir_value=IDCODE; ir_sr=0; id_sr=IDCODE_VALUE; bypass_sr=0; user_sr=0.
  - user_update_data=0; user_update_valid=0; abort_pulse=0; tdo=0; tdo_en=0.
  - Reset asserted mid-scan aborts the scan immediately; no update strobe is produced.
- Actions per rising tck, keyed on tap_state sampled that edge:
  - TestLogicReset: ir_value<=IDCODE. Shift registers hold.
  - CaptureIr: ir_sr<=4'b0101 (LSBs 01 per 1149.1).
  - ShiftIr: ir_sr<={tdi, ir_sr[IR_WIDTH-1:1]}.
  - UpdateIr: ir_value<=ir_sr.
  - CaptureDr, selected chain only: id_sr<=IDCODE_VALUE; bypass_sr<=0; user_sr<=user_capture_data.
  - ShiftDr, selected chain only: shift right, tdi enters MSB, LSB is first out. BYPASS is a 1-bit stage: bypass_sr<=tdi.
  - UpdateDr: if USER, user_update_data<=user_sr and user_update_valid=1 for exactly one cycle. If ABORT, abort_pulse=1 for exactly one cycle. Other instructions: no action.
  - Pause, Exit, Select and RunTestOrIdle states: all registers hold.
  - Unlisted tap_state codes: no-op.
- tdo and tdo_en are combinational from tap_state and registers only, with no path from tdi:
  - ShiftIr: tdo=ir_sr[0].
  - ShiftDr: tdo = LSB of the selected chain.
  - Otherwise: tdo=0.
  - tdo_en=1 exactly in ShiftIr or ShiftDr.
- Latency: a bit entering on tdi at edge n appears on tdo after BYPASS: 1 edge; USER: USER_WIDTH edges; IDCODE: 32 edges.
- ir_value changes only at UpdateIr or TestLogicReset. A changed instruction takes effect from the next CaptureDr.
- Exit2 back to Shift resumes the shift with no data loss. Shifting more than the chain length recirculates tdi, which reappears on tdo after the chain length.
- Strobes are never asserted in consecutive cycles, since UpdateDr always lasts one tck.

Test Plan:
- Reset, then TestLogicReset→RunTestOrIdle→SelectDrScan→CaptureDr→32×ShiftDr, tdi=0 → tdo sequence read LSB first equals 0x000FAF01; tdo_en=1 only during the 32 ShiftDr cycles.
- SelectIrScan→CaptureIr→4×ShiftIr with tdi=1,1,1,1 → tdo=1,0,1,0. After UpdateIr, ir_value=0xF. Then CaptureDr + ShiftDr with tdi=1,0,1,1 → tdo=0,1,0,1.
- Load IR=0xA, user_capture_data=0xA5, 8×ShiftDr with tdi=0x3C LSB first → tdo=0xA5 LSB first. At UpdateDr, user_update_data=0x3C and user_update_valid high for exactly one cycle.
- Load IR=0x3 (undefined) → DR scan behaves as BYPASS (1-cycle delay). Load IR=0x8 then UpdateDr → abort_pulse high for one cycle, user_update_valid stays 0.
- Assert trst mid-ShiftDr of USER → tdo=0, tdo_en=0 and ir_value=0xE without a clock edge. No user_update_valid follows.
- ir_value=0xF, then 5 cycles in TestLogicReset → ir_value=0xE, and the next DR scan returns 0x000FAF01.
